gate_list_execute_sm: RTL and testbench
=======================================

GATE_LIST_EXECUTE_SM -- requirements
Module: gate_list_execute_sm

Interface
REQ-001 SHALL have parameter LIST_DEPTH, default 8: number of gate control list entries (power of 2, 2..64).
REQ-002 SHALL have parameter NS_PER_CLK, default 8: nanoseconds elapsed per clk cycle (1..255).
REQ-003 SHALL have parameter ADMIN_GATE_STATES, default 8'hFF: gate vector applied at reset and while disabled.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-low (0 = reset).
REQ-006 SHALL have port gate_enable  in  1  1 = list execution permitted; 0 = force admin gates.
REQ-007 SHALL have port CycleStart  in  1  one-cycle pulse from the cycle timer marking a new gating cycle.
REQ-008 SHALL have port cfg_we  in  1  list table write strobe.
REQ-009 SHALL have port cfg_addr  in  6  list entry index to write.
REQ-010 SHALL have port cfg_gate  in  8  gate state vector for the entry (bit n = traffic class n open).
REQ-011 SHALL have port cfg_interval  in  32  entry time interval in ns.
REQ-012 SHALL have port cfg_list_len  in  7  number of valid entries (0..LIST_DEPTH).
REQ-013 SHALL have port oper_gate_states  out  8  currently applied gate vector, registered.
REQ-014 SHALL have port list_index  out  6  index of entry currently applied.
REQ-015 SHALL have port executing  out  1  1 while a list is being walked.
REQ-016 SHALL have port entry_change  out  1  one-cycle pulse on every cycle a new entry is applied.

Function
REQ-017 SHALL implement states IDLE, DELAY; transitions only as specified below.
REQ-018 SHALL write cfg_gate/cfg_interval to entry cfg_addr on any clk edge with cfg_we=1, in any state; cfg_addr >= LIST_DEPTH SHALL be ignored.
REQ-019 SHALL latch cfg_list_len into an internal length register only at an accepted CycleStart; values > LIST_DEPTH SHALL be clamped to LIST_DEPTH.
REQ-020 SHALL accept CycleStart when gate_enable=1 and cfg_list_len != 0; otherwise ignore it (no output change).
REQ-021 On accepted CycleStart at edge T (any state, including mid-list in DELAY): entry 0 gates, list_index=0, entry_change=1, executing=1 visible after edge T; state DELAY.
REQ-022 Entry k applied at edge A SHALL remain applied for D = max(1, ceil(interval_k / NS_PER_CLK)) cycles; next entry applied at edge A+D.
REQ-023 Remaining-time counter SHALL be 32-bit, loaded with interval_k at apply, decremented by NS_PER_CLK per cycle; advance when remaining <= NS_PER_CLK; no underflow wrap.
REQ-024 Interval value read SHALL be the table content at apply time; writes to the active entry after apply SHALL not alter the running countdown.
REQ-025 After the last entry (index = length-1) expires: oper_gate_states SHALL hold that entry's gates, executing=0, entry_change=0, state IDLE, list_index unchanged.
REQ-026 CycleStart coinciding with last-entry expiry SHALL restart at entry 0 (CycleStart has priority over advance/end).
REQ-027 gate_enable=0 SHALL, at the next edge, force oper_gate_states=ADMIN_GATE_STATES, list_index=0, executing=0, state IDLE; overrides CycleStart on the same edge.
REQ-028 entry_change SHALL be 1 for exactly one cycle per apply, including restarts to entry 0.

Reset
REQ-029 While rst=0, asynchronously: state IDLE, oper_gate_states=ADMIN_GATE_STATES, list_index=0, executing=0, entry_change=0, counter=0, length=0.
REQ-030 Table contents SHALL reset to gate 8'h00, interval 0; reset mid-list SHALL abandon the walk with no further entry_change.

Verification
REQ-031 Table {0:8'h01/24ns, 1:8'h02/20ns, 2:8'h80/0ns}, len 3, NS_PER_CLK=8, CycleStart at edge T -> gates 01 on T..T+2, 02 on T+3..T+5, 80 on T+6, executing falls after T+7, gates hold 80.
REQ-032 Same table, second CycleStart at edge T+4 -> gates 01 at T+4, entry_change=1 at T+4, list_index=0.
REQ-033 cfg_list_len=0, CycleStart pulse -> oper_gate_states stays FF, executing=0, no entry_change.
REQ-034 gate_enable dropped to 0 during entry 1 -> next edge gates=FF, executing=0; CycleStart on that same edge ignored.
REQ-035 rst=0 asserted mid-entry between edges -> outputs immediately ADMIN/0/0/0; after release, CycleStart required to resume.
REQ-036 cfg_we to cfg_addr=63 with LIST_DEPTH=8, then full walk -> entries 0..7 unchanged, no X on outputs.

Source files
------------

// File: rtl/gate_list_execute_sm.sv
`default_nettype none
// ============================================================================
// Module      : gate_list_execute_sm
// Description : Walks a gate control list. Each entry is applied for its time
//               interval, and the list restarts from entry 0 on every accepted
//               CycleStart pulse.
//               The list table is written through the cfg_* port and can be
//               written in any state.
// Ports       : clk               - single clock, rising edge
//               rst               - asynchronous reset, active low
//               gate_enable       - 1 = list execution permitted
//               CycleStart        - one-cycle pulse marking a new gating cycle
//               cfg_we/cfg_addr   - table write strobe / entry index
//               cfg_gate          - gate vector written to the entry
//               cfg_interval      - interval in ns written to the entry
//               cfg_list_len      - number of valid entries, sampled at start
//               oper_gate_states  - applied gate vector (registered)
//               list_index        - index of the applied entry
//               executing         - 1 while a list is being walked
//               entry_change      - one-cycle pulse per applied entry
// Revision    : 1.0 - initial release
// ============================================================================
module gate_list_execute_sm #(
    parameter int          LIST_DEPTH        = 8,
    parameter int          NS_PER_CLK        = 8,
    parameter logic [7:0]  ADMIN_GATE_STATES = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate_enable,
    input  logic        CycleStart,
    input  logic        cfg_we,
    input  logic [5:0]  cfg_addr,
    input  logic [7:0]  cfg_gate,
    input  logic [31:0] cfg_interval,
    input  logic [6:0]  cfg_list_len,
    output logic [7:0]  oper_gate_states,
    output logic [5:0]  list_index,
    output logic        executing,
    output logic        entry_change
);

    localparam int          c_iw    = $clog2(LIST_DEPTH);
    localparam logic [6:0]  c_depth = 7'(LIST_DEPTH);
    localparam logic [31:0] c_ns    = 32'(NS_PER_CLK);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DELAY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  gates_q, gates_d;
    logic [5:0]  idx_q, idx_d;
    logic        chg_q, chg_d;
    logic [31:0] rem_q, rem_d;
    logic [6:0]  len_q, len_d;

    logic [7:0]  tbl_gate_q [LIST_DEPTH];
    logic [31:0] tbl_ivl_q  [LIST_DEPTH];

    logic        w_start;
    logic        w_last;
    logic [5:0]  w_nidx;
    logic [6:0]  w_len_clamped;

    // List table. Writes beyond the table are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LIST_DEPTH; i++) begin
                tbl_gate_q[i] <= 8'h00;
                tbl_ivl_q[i]  <= 32'd0;
            end
        end else if (cfg_we && ({1'b0, cfg_addr} < c_depth)) begin
            tbl_gate_q[cfg_addr[c_iw-1:0]] <= cfg_gate;
            tbl_ivl_q[cfg_addr[c_iw-1:0]]  <= cfg_interval;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gates_q <= ADMIN_GATE_STATES;
            idx_q   <= 6'd0;
            chg_q   <= 1'b0;
            rem_q   <= 32'd0;
            len_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            gates_q <= gates_d;
            idx_q   <= idx_d;
            chg_q   <= chg_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
        end
    end

    assign w_start       = CycleStart && (cfg_list_len != 7'd0);
    assign w_len_clamped = (cfg_list_len > c_depth) ? c_depth : cfg_list_len;
    // len_q is never zero while in DELAY, so len_q-1 cannot wrap there.
    assign w_last        = ({1'b0, idx_q} == (len_q - 7'd1));
    assign w_nidx        = idx_q + 6'd1;

    // Priority: disable > CycleStart > countdown/advance/end of list.
    always_comb begin
        state_d = state_q;
        gates_d = gates_q;
        idx_d   = idx_q;
        chg_d   = 1'b0;
        rem_d   = rem_q;
        len_d   = len_q;
        if (!gate_enable) begin
            state_d = IDLE;
            gates_d = ADMIN_GATE_STATES;
            idx_d   = 6'd0;
            rem_d   = 32'd0;
        end else if (w_start) begin
            state_d = DELAY;
            gates_d = tbl_gate_q[0];
            idx_d   = 6'd0;
            chg_d   = 1'b1;
            rem_d   = tbl_ivl_q[0];
            len_d   = w_len_clamped;
        end else if (state_q == DELAY) begin
            // Advancing at remaining <= NS_PER_CLK yields max(1, ceil(ivl/ns))
            // cycles per entry and never lets the counter wrap below zero.
            if (rem_q <= c_ns) begin
                if (w_last) begin
                    state_d = IDLE;
                    rem_d   = 32'd0;
                end else begin
                    idx_d   = w_nidx;
                    gates_d = tbl_gate_q[w_nidx[c_iw-1:0]];
                    rem_d   = tbl_ivl_q[w_nidx[c_iw-1:0]];
                    chg_d   = 1'b1;
                end
            end else begin
                rem_d = rem_q - c_ns;
            end
        end
    end

    assign oper_gate_states = gates_q;
    assign list_index       = idx_q;
    assign executing        = (state_q == DELAY);
    assign entry_change     = chg_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_list_execute_sm.sv
`default_nettype none
module tb_gate_list_execute_sm;

    logic        clk = 1'b0;
    logic        rst;
    logic        gate_enable;
    logic        CycleStart;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_gate;
    logic [31:0] cfg_interval;
    logic [6:0]  cfg_list_len;
    logic [7:0]  oper_gate_states;
    logic [5:0]  list_index;
    logic        executing;
    logic        entry_change;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] g;
        logic [5:0] i;
        logic       e;
        logic       c;
        string      tag;
    } exp_t;

    exp_t sb[$];

    gate_list_execute_sm #(
        .LIST_DEPTH(8),
        .NS_PER_CLK(8),
        .ADMIN_GATE_STATES(8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gate_enable(gate_enable),
        .CycleStart(CycleStart),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_gate(cfg_gate),
        .cfg_interval(cfg_interval),
        .cfg_list_len(cfg_list_len),
        .oper_gate_states(oper_gate_states),
        .list_index(list_index),
        .executing(executing),
        .entry_change(entry_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] g, input logic [5:0] i,
                           input logic e, input logic c);
        chk({tag, ".gates"}, {24'd0, oper_gate_states}, {24'd0, g});
        chk({tag, ".idx"},   {26'd0, list_index},       {26'd0, i});
        chk({tag, ".exec"},  {31'd0, executing},        {31'd0, e});
        chk({tag, ".chg"},   {31'd0, entry_change},     {31'd0, c});
    endtask

    // Push the expectation for the coming edge, advance one cycle, then pop
    // and compare against what the DUT shows just after that edge.
    task automatic cyc(input string tag, input logic [7:0] g, input logic [5:0] i,
                       input logic e, input logic c);
        exp_t x;
        x.g = g; x.i = i; x.e = e; x.c = c; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk_all(x.tag, x.g, x.i, x.e, x.c);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] g, input logic [31:0] v,
                      input string tag, input logic [7:0] eg, input logic [5:0] ei);
        cfg_we = 1'b1; cfg_addr = a; cfg_gate = g; cfg_interval = v;
        cyc(tag, eg, ei, 1'b0, 1'b0);
        cfg_we = 1'b0;
    endtask

    function automatic int dur(input logic [31:0] v);
        return (v == 0) ? 1 : int'((v + 32'd7) / 32'd8);
    endfunction

    function automatic logic [31:0] ivl_of(input int k);
        return 32'(k * 8 + ((k % 2 == 1) ? 3 : 0));
    endfunction

    initial begin
        rst = 1'b0; gate_enable = 1'b0; CycleStart = 1'b0; cfg_we = 1'b0;
        cfg_addr = 6'd0; cfg_gate = 8'd0; cfg_interval = 32'd0; cfg_list_len = 7'd0;

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'hFF, 6'd0, 1'b0, 1'b0);
        #3 rst = 1'b1;

        // Load the basic three-entry table while disabled.
        wr(6'd0, 8'h01, 32'd24, "wr0", 8'hFF, 6'd0);
        wr(6'd1, 8'h02, 32'd20, "wr1", 8'hFF, 6'd0);
        wr(6'd2, 8'h80, 32'd0,  "wr2", 8'hFF, 6'd0);

        // Zero-length list: CycleStart ignored.
        gate_enable = 1'b1; cfg_list_len = 7'd0; CycleStart = 1'b1;
        cyc("len0", 8'hFF, 6'd0, 1'b0, 1'b0);
        CycleStart = 1'b0;
        cyc("len0_after", 8'hFF, 6'd0, 1'b0, 1'b0);

        // Full three-entry walk.
        cfg_list_len = 7'd3; CycleStart = 1'b1;
        cyc("walk_T", 8'h01, 6'd0, 1'b1, 1'b1);
        CycleStart = 1'b0;
        cyc("walk_T1", 8'h01, 6'd0, 1'b1, 1'b0);
        cyc("walk_T2", 8'h01, 6'd0, 1'b1, 1'b0);
        cyc("walk_T3", 8'h02, 6'd1, 1'b1, 1'b1);
        cyc("walk_T4", 8'h02, 6'd1, 1'b1, 1'b0);
        cyc("walk_T5", 8'h02, 6'd1, 1'b1, 1'b0);
        cyc("walk_T6", 8'h80, 6'd2, 1'b1, 1'b1);
        cyc("walk_T7", 8'h80, 6'd2, 1'b0, 1'b0);
        cyc("walk_hold", 8'h80, 6'd2, 1'b0, 1'b0);

        // Restart mid-list at T+4.
        CycleStart = 1'b1;
        cyc("rs_T", 8'h01, 6'd0, 1'b1, 1'b1);
        CycleStart = 1'b0;
        cyc("rs_T1", 8'h01, 6'd0, 1'b1, 1'b0);
        cyc("rs_T2", 8'h01, 6'd0, 1'b1, 1'b0);
        cyc("rs_T3", 8'h02, 6'd1, 1'b1, 1'b1);
        CycleStart = 1'b1;
        cyc("rs_T4", 8'h01, 6'd0, 1'b1, 1'b1);
        CycleStart = 1'b0;
        cyc("rs_T5", 8'h01, 6'd0, 1'b1, 1'b0);
        cyc("rs_T6", 8'h01, 6'd0, 1'b1, 1'b0);
        cyc("rs_T7", 8'h02, 6'd1, 1'b1, 1'b1);
        cyc("rs_T8", 8'h02, 6'd1, 1'b1, 1'b0);
        cyc("rs_T9", 8'h02, 6'd1, 1'b1, 1'b0);
        cyc("rs_T10", 8'h80, 6'd2, 1'b1, 1'b1);

        // CycleStart coinciding with last-entry expiry wins.
        CycleStart = 1'b1;
        cyc("last_cs", 8'h01, 6'd0, 1'b1, 1'b1);
        CycleStart = 1'b0;
        cyc("dis_S1", 8'h01, 6'd0, 1'b1, 1'b0);
        cyc("dis_S2", 8'h01, 6'd0, 1'b1, 1'b0);
        cyc("dis_S3", 8'h02, 6'd1, 1'b1, 1'b1);

        // Disable during entry 1, with a CycleStart on the same edge.
        gate_enable = 1'b0; CycleStart = 1'b1;
        cyc("dis_edge", 8'hFF, 6'd0, 1'b0, 1'b0);
        CycleStart = 1'b0;
        cyc("dis_hold", 8'hFF, 6'd0, 1'b0, 1'b0);
        gate_enable = 1'b1;
        cyc("en_nocs", 8'hFF, 6'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-entry.
        CycleStart = 1'b1;
        cyc("pre_rst0", 8'h01, 6'd0, 1'b1, 1'b1);
        CycleStart = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_all("async_rst", 8'hFF, 6'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc("post_rst1", 8'hFF, 6'd0, 1'b0, 1'b0);
        cyc("post_rst2", 8'hFF, 6'd0, 1'b0, 1'b0);

        // Table was cleared by reset: gates 00, interval 0 -> one cycle each.
        CycleStart = 1'b1;
        cyc("clr0", 8'h00, 6'd0, 1'b1, 1'b1);
        CycleStart = 1'b0;
        cyc("clr1", 8'h00, 6'd1, 1'b1, 1'b1);
        cyc("clr2", 8'h00, 6'd2, 1'b1, 1'b1);
        cyc("clr_end", 8'h00, 6'd2, 1'b0, 1'b0);

        // Full eight-entry table, an out-of-range write, clamped length.
        gate_enable = 1'b0;
        for (int k = 0; k < 8; k++)
            wr(6'(k), 8'(8'h11 * (k + 1)), ivl_of(k), $sformatf("wrf%0d", k), 8'hFF, 6'd0);
        wr(6'd63, 8'h5A, 32'd16, "wr63", 8'hFF, 6'd0);
        gate_enable = 1'b1; cfg_list_len = 7'd100; CycleStart = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < dur(ivl_of(k)); c++) begin
                cyc($sformatf("full_e%0d_c%0d", k, c), 8'(8'h11 * (k + 1)), 6'(k), 1'b1, (c == 0));
                CycleStart = 1'b0;
                cfg_we = 1'b0;
                // Rewriting the active entry must not disturb its countdown.
                if (k == 3 && c == 0) begin
                    cfg_we = 1'b1; cfg_addr = 6'd3; cfg_gate = 8'h00; cfg_interval = 32'd0;
                end
            end
        end
        cyc("full_end", 8'h88, 6'd7, 1'b0, 1'b0);
        cyc("full_hold", 8'h88, 6'd7, 1'b0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
